// File: rtl/count_mc.sv
// count_mc: multi-channel up/down counter with per-channel limit, wrap/saturate mode and sticky overflow
//   clk, rst_n (async active-low); per channel c: ld_n, cen, up_dn, sat, din[c*WIDTH+:WIDTH], ovf_clr;
//   shared limit write port lim_we/lim_sel/lim_din; outputs cnt_out (same packing as din), tc, zero, ovf.
module count_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       ld_n,
  input  logic [CHANNELS-1:0]       cen,
  input  logic [CHANNELS-1:0]       up_dn,
  input  logic [CHANNELS-1:0]       sat,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      lim_we,
  input  logic [SEL_W-1:0]          lim_sel,
  input  logic [WIDTH-1:0]          lim_din,
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic [CHANNELS*WIDTH-1:0] cnt_out,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       ovf
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] cnt, lim, ld_val, nxt;
    logic             evt, ovf_r;
    assign ld_val = din[c*WIDTH +: WIDTH];
    // Counting down from above a freshly lowered limit snaps to the limit without an event,
    // so the down boundary is only ever cnt == 0.
    always_comb begin
      nxt = cnt;
      evt = 1'b0;
      if (!ld_n[c]) nxt = (ld_val > lim) ? lim : ld_val;
      else if (cen[c] && up_dn[c]) begin
        evt = cnt >= lim;
        nxt = evt ? (sat[c] ? lim : '0) : cnt + 1'b1;
      end else if (cen[c]) begin
        evt = cnt == '0;
        nxt = (cnt > lim) ? lim : evt ? (sat[c] ? '0 : lim) : cnt - 1'b1;
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        lim   <= '1;
        ovf_r <= 1'b0;
      end else begin
        cnt   <= nxt;
        ovf_r <= evt | (ovf_r & ~ovf_clr[c]);
        if (lim_we && lim_sel == SEL_W'(c)) lim <= lim_din;
      end
    end
    assign cnt_out[c*WIDTH +: WIDTH] = cnt;
    assign tc[c]   = cnt == lim;
    assign zero[c] = cnt == '0;
    assign ovf[c]  = ovf_r;
  end
endmodule

// File: tb/tb_count_mc.sv
// tb_count_mc: randomized and directed self-checking bench for count_mc against a behavioural model
module tb_count_mc;
  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] ld_n = '1, cen = '0, up_dn = '0, sat = '0, ovf_clr = '0;
  logic [N*W-1:0] din = '0;
  logic lim_we = 1'b0;
  logic [S-1:0] lim_sel = '0;
  logic [W-1:0] lim_din = '0;
  logic [N*W-1:0] cnt_out;
  logic [N-1:0] tc, zero, ovf;
  int checks = 0, failures = 0;
  bit chk_en = 0;
  int m_cnt[N], m_lim[N];
  bit m_ovf[N];

  always #5 clk = ~clk;

  count_mc #(.WIDTH(W), .CHANNELS(N), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .ld_n(ld_n), .cen(cen), .up_dn(up_dn), .sat(sat),
    .din(din), .lim_we(lim_we), .lim_sel(lim_sel), .lim_din(lim_din), .ovf_clr(ovf_clr),
    .cnt_out(cnt_out), .tc(tc), .zero(zero), .ovf(ovf)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer rules per channel; limits are updated after the counts so a
  // count in the write cycle sees the old limit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_cnt[c] = 0;
        m_lim[c] = (1 << W) - 1;
        m_ovf[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        int d;
        bit ev;
        d = int'(din[c*W +: W]);
        ev = 0;
        if (!ld_n[c]) m_cnt[c] = (d < m_lim[c]) ? d : m_lim[c];
        else if (cen[c] && up_dn[c]) begin
          if (m_cnt[c] < m_lim[c]) m_cnt[c]++;
          else begin
            ev = 1;
            m_cnt[c] = sat[c] ? m_lim[c] : 0;
          end
        end else if (cen[c]) begin
          if (m_cnt[c] > m_lim[c]) m_cnt[c] = m_lim[c];
          else if (m_cnt[c] == 0) begin
            ev = 1;
            m_cnt[c] = sat[c] ? 0 : m_lim[c];
          end else m_cnt[c]--;
        end
        m_ovf[c] = ev || (m_ovf[c] && !ovf_clr[c]);
      end
      if (lim_we && int'(lim_sel) < N) m_lim[lim_sel] = int'(lim_din);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < N; c++) begin
        chk($sformatf("model_cnt%0d", c), 32'(cnt_out[c*W +: W]), m_cnt[c]);
        chk($sformatf("model_tc%0d", c), 32'(tc[c]), 32'(m_cnt[c] == m_lim[c]));
        chk($sformatf("model_zero%0d", c), 32'(zero[c]), 32'(m_cnt[c] == 0));
        chk($sformatf("model_ovf%0d", c), 32'(ovf[c]), 32'(m_ovf[c]));
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wlim(int s, int v);
    lim_we = 1'b1;
    lim_sel = S'(s);
    lim_din = W'(v);
    step();
    lim_we = 1'b0;
  endtask

  task automatic load(int c, int v);
    ld_n[c] = 1'b0;
    din[c*W +: W] = W'(v);
    step();
    ld_n[c] = 1'b1;
  endtask

  function automatic logic [31:0] cv(int c);
    return 32'(cnt_out[c*W +: W]);
  endfunction

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1;
    chk("rst_cnt", cnt_out, 0);
    chk("rst_zero", 32'(zero), 32'hF);
    chk("rst_tc", 32'(tc), 0);
    chk("rst_ovf", 32'(ovf), 0);
    // mid-count asynchronous reset, limits included
    cen = 4'b0001; up_dn = 4'b0001;
    step(5);
    chk("pre_rst_cnt0", cv(0), 5);
    cen = '0;
    wlim(1, 9);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_cnt", cnt_out, 0);
    chk("async_rst_zero", 32'(zero), 32'hF);
    #1 rst_n = 1'b1;
    @(negedge clk);
    load(1, 9);
    chk("lim_reset_cnt1", cv(1), 9);
    chk("lim_reset_tc1", 32'(tc[1]), 0);
    load(1, 0);
    // full-range wrap on channel 0
    cen = 4'b0001; up_dn = 4'b0001;
    step(255);
    chk("c0_255", cv(0), 255);
    chk("c0_tc255", 32'(tc[0]), 1);
    chk("c0_ovf_pre", 32'(ovf[0]), 0);
    step();
    chk("c0_wrap", cv(0), 0);
    chk("c0_ovf", 32'(ovf[0]), 1);
    cen = '0;
    // modulo wrap, limit 9
    wlim(1, 9);
    cen[1] = 1'b1; up_dn[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("mod_cnt1", cv(1), (i <= 9) ? i : i - 10);
      chk("mod_tc1", 32'(tc[1]), 32'(i == 9));
      chk("mod_ovf1", 32'(ovf[1]), 32'(i >= 10));
    end
    cen = '0;
    ovf_clr[1] = 1'b1; step(); ovf_clr = '0;
    chk("clr_ovf1", 32'(ovf[1]), 0);
    load(1, 0);
    cen[1] = 1'b1; up_dn[1] = 1'b0;
    step();
    chk("mod_down_cnt1", cv(1), 9);
    chk("mod_down_ovf1", 32'(ovf[1]), 1);
    cen = '0;
    // saturate, limit 5
    wlim(2, 5);
    sat[2] = 1'b1; cen[2] = 1'b1; up_dn[2] = 1'b1;
    step(8);
    chk("sat_cnt2", cv(2), 5);
    chk("sat_ovf2", 32'(ovf[2]), 1);
    cen = '0;
    ovf_clr[2] = 1'b1; step(); ovf_clr = '0;
    load(2, 0);
    cen[2] = 1'b1; up_dn[2] = 1'b0;
    step();
    chk("sat_down_cnt2", cv(2), 0);
    chk("sat_down_zero2", 32'(zero[2]), 1);
    chk("sat_down_ovf2", 32'(ovf[2]), 1);
    cen = '0;
    // load priority and clamp
    wlim(3, 100);
    din[3*W +: W] = 8'd200; ld_n[3] = 1'b0; cen[3] = 1'b1; up_dn[3] = 1'b1;
    step();
    chk("ld_clamp_cnt3", cv(3), 100);
    chk("ld_clamp_ovf3", 32'(ovf[3]), 0);
    din[3*W +: W] = 8'd7;
    step();
    chk("ld_cnt3", cv(3), 7);
    ld_n = '1; cen = '0;
    // limit change while counting
    ovf_clr[0] = 1'b1;
    load(0, 50);
    ovf_clr = '0;
    chk("lc_load_cnt0", cv(0), 50);
    cen[0] = 1'b1; up_dn[0] = 1'b1;
    wlim(0, 20);
    chk("lc_old_lim_cnt0", cv(0), 51);
    chk("lc_old_lim_ovf0", 32'(ovf[0]), 0);
    step();
    chk("lc_wrap_cnt0", cv(0), 0);
    chk("lc_wrap_ovf0", 32'(ovf[0]), 1);
    cen = '0;
    ovf_clr[0] = 1'b1;
    wlim(0, 255);
    ovf_clr = '0;
    load(0, 50);
    wlim(0, 20);
    cen[0] = 1'b1; up_dn[0] = 1'b0;
    step();
    chk("lc_down_cnt0", cv(0), 20);
    chk("lc_down_ovf0", 32'(ovf[0]), 0);
    chk("lc_down_tc0", 32'(tc[0]), 1);
    cen = '0;
    // overflow set beats clear
    ovf_clr[1] = 1'b1; step();
    cen[1] = 1'b1; up_dn[1] = 1'b1;
    step();
    chk("race_cnt1", cv(1), 0);
    chk("race_ovf1", 32'(ovf[1]), 1);
    cen = '0;
    step();
    chk("clr_only_ovf1", 32'(ovf[1]), 0);
    ovf_clr = '0;
    chk("iso_cnt3", cv(3), 7);
    chk("iso_cnt2", cv(2), 0);
    // randomized phase
    repeat (3000) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      for (int c = 0; c < N; c++) begin
        ld_n[c] = ($urandom_range(0, 9) != 0);
        din[c*W +: W] = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 20));
      end
      cen = N'($urandom);
      up_dn = N'($urandom_range(0, 3) == 0 ? $urandom : '1);
      sat = N'($urandom);
      ovf_clr = N'($urandom_range(0, 5) == 0 ? $urandom : 0);
      lim_we = ($urandom_range(0, 7) == 0);
      lim_sel = S'($urandom);
      lim_din = W'($urandom_range(0, 7) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 16));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
